iterative_left_shift: RTL and testbench

Multi-cycle logical left shifter for the 8-bit ALU: it shifts an 8-bit operand left by a 5-bit amount, one bit position per clock. It is the left-direction companion of the combinational right shifter and sits in the ALU shift path where the controller sequences long shifts. It also reports the last bit shifted out (carry) and a zero flag, both of which the status register consumes.

---
 rtl/iterative_left_shift.sv | 114 +++++++++++
 tb/tb_iterative_left_shift.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/iterative_left_shift.sv
// ---------------------------------------------------------------------------
// iterative_left_shift
//
// Multi-cycle logical left shifter for the 8-bit ALU shift path. Shifts an
// 8-bit operand left by a 5-bit amount, one bit position per clock. It
// reports the last bit shifted out of bit 7 (carry) and a zero flag for the
// status register.
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset
//   start  in   1  shift request, accepted only in IDLE or DONE
//   in     in   8  operand, sampled with an accepted start
//   shamt  in   5  shift amount 0..31, sampled with an accepted start
//   out    out  8  working/result register, valid while done=1 and held
//   carry  out  1  last bit shifted out of bit 7 (0 if no shift happened)
//   zero   out  1  out == 0
//   busy   out  1  high while shifting
//   done   out  1  one-cycle result-valid pulse
// ---------------------------------------------------------------------------
module iterative_left_shift (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] in,
    input  logic [4:0] shamt,
    output logic [7:0] out,
    output logic       carry,
    output logic       zero,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_q;
    logic [7:0] out_q;
    logic       carry_q;
    logic [3:0] count_q;
    logic       busy_q;
    logic       done_q;
    logic [3:0] count_d;

    // Nine shifts already flush every operand bit and a zero into carry, so
    // larger amounts are clamped to 9 to bound latency.
    always_comb begin
        count_d = '0;
        if (shamt > 5'd9) begin
            count_d = 4'd9;
        end else begin
            count_d = shamt[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        out_q   <= in;
                        carry_q <= 1'b0;
                        count_q <= count_d;
                        if (count_d == 4'd0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SHIFT;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    carry_q <= out_q[7];
                    out_q   <= {out_q[6:0], 1'b0};
                    count_q <= count_q - 4'd1;
                    if (count_q == 4'd1) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out   = out_q;
    assign carry = carry_q;
    assign zero  = (out_q == '0);
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_iterative_left_shift.sv
module tb_iterative_left_shift;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] din;
    logic [4:0] shamt;
    logic [7:0] dout;
    logic       carry;
    logic       zero;
    logic       busy;
    logic       done;

    iterative_left_shift dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in    (din),
        .shamt (shamt),
        .out   (dout),
        .carry (carry),
        .zero  (zero),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  o;
        logic        c;
        int unsigned nb;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned pcyc  = 0;
    int unsigned busy_cnt = 0;
    logic [7:0]  last_out;

    always @(posedge clk) pcyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    // Reference: logical left shift by min(s,9), carry = last bit out of bit 7.
    task automatic model(input logic [7:0] a, input logic [4:0] s,
                         output logic [7:0] o, output logic c, output int unsigned n);
        o = a;
        c = 1'b0;
        n = (s > 5'd9) ? 9 : int'(s);
        for (int i = 0; i < n; i++) begin
            c = o[7];
            o = {o[6:0], 1'b0};
        end
    endtask

    // Call at a negedge: drives start for the next rising edge and records
    // the expected result and the pcyc value at which done must be seen.
    task automatic issue(input logic [7:0] a, input logic [4:0] s);
        exp_t e;
        start = 1'b1;
        din   = a;
        shamt = s;
        model(a, s, e.o, e.c, e.nb);
        e.cyc = pcyc + 1 + e.nb;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        bit found = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        if (!found) chk("done_timeout", {31'b0, done}, 32'd1);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [4:0] s);
        @(negedge clk);
        issue(a, s);
        @(negedge clk);
        start = 1'b0;
        wait_done();
    endtask

    // Monitor: checks every done pulse against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", {31'b0, done}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out",      {24'b0, dout},  {24'b0, e.o});
                    chk("carry",    {31'b0, carry}, {31'b0, e.c});
                    chk("zero",     {31'b0, zero},  {31'b0, (e.o == 8'h00)});
                    chk("busy_len", busy_cnt,       e.nb);
                    chk("latency",  pcyc,           e.cyc);
                    chk("busy_with_done", {31'b0, busy}, 32'd0);
                    last_out = e.o;
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        din   = '0;
        shamt = '0;
        #1;
        chk("rst_out",   {24'b0, dout},  32'h0);
        chk("rst_carry", {31'b0, carry}, 32'd0);
        chk("rst_zero",  {31'b0, zero},  32'd1);
        chk("rst_busy",  {31'b0, busy},  32'd0);
        chk("rst_done",  {31'b0, done},  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        run_op(8'h81, 5'd1);
        run_op(8'hB4, 5'd3);
        run_op(8'h5A, 5'd0);
        run_op(8'h01, 5'd8);
        run_op(8'hFF, 5'd20);
        run_op(8'h80, 5'd9);
        run_op(8'h7F, 5'd31);

        // Outputs hold in IDLE
        repeat (5) @(negedge clk);
        chk("idle_hold_out",  {24'b0, dout}, {24'b0, last_out});
        chk("idle_hold_busy", {31'b0, busy}, 32'd0);

        // Start while busy is ignored; back-to-back start on the done cycle
        @(negedge clk);
        issue(8'h0F, 5'd4);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        din   = 8'hFF;
        shamt = 5'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        issue(8'hC3, 5'd2);
        @(negedge clk);
        start = 1'b0;
        wait_done();
        // Back-to-back zero-amount op issued on a done cycle
        issue(8'h3C, 5'd0);
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Asynchronous reset mid-shift
        @(negedge clk);
        issue(8'hA5, 5'd5);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_out",   {24'b0, dout},  32'h0);
        chk("mid_rst_carry", {31'b0, carry}, 32'd0);
        chk("mid_rst_zero",  {31'b0, zero},  32'd1);
        chk("mid_rst_busy",  {31'b0, busy},  32'd0);
        chk("mid_rst_done",  {31'b0, done},  32'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("no_done_after_rst", {31'b0, done}, 32'd0);
        run_op(8'h96, 5'd2);

        // Random ops
        for (int k = 0; k < 12; k++) begin
            run_op(8'($urandom_range(0, 255)), 5'($urandom_range(0, 31)));
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end

endmodule
